// File: rtl/ptmch_pkg.sv
// ptmch_pkg: shared types and constants for the ptmch SPI command initiator.
// Holds the initiator FSM state enum, the flash opcodes the ptmch
// instruction-trigger path recognises, and the frame-length clamp.
`timescale 1ns/1ps
package ptmch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   localparam logic [7:0] OP_PROGRAM_EXECUTE  = 8'h10;
   localparam logic [7:0] OP_READ_STATUS1     = 8'h0F;
   localparam logic [7:0] OP_READ_STATUS2     = 8'h05;
   localparam logic [7:0] OP_BLOCK_ERASE_128K = 8'hD8;
   localparam logic [7:0] OP_PAGE_DATA_READ   = 8'h13;
   localparam logic [7:0] OP_WRITE_STATUS1    = 8'h1F;
   localparam logic [7:0] OP_WRITE_STATUS2    = 8'h01;

   // A zero-length request still sends the opcode; oversize requests are cut
   // to the longest frame the shift register can hold.
   function automatic int clamp_nbytes(input int n, input int max_bytes);
      if (n == 0) begin
         return 1;
      end else if (n > max_bytes) begin
         return max_bytes;
      end else begin
         return n;
      end
   endfunction

endpackage

// File: rtl/ptmch_spi_sck_gen.sv
// ptmch_spi_sck_gen: SCK divider. While enabled, SCK toggles every P_CLK_DIV
// clocks, first toggle being a rise. rise_o/fall_o flag the cycle whose
// closing edge moves SCK, so the caller can update MOSI on the same edge.
`timescale 1ns/1ps
module ptmch_spi_sck_gen #(
   parameter int P_CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = $clog2(P_CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(P_CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          sck_q;
   logic          tick;

   assign tick   = en_i && (cnt_q == CNT_LAST);
   assign rise_o = tick && !sck_q;
   assign fall_o = tick && sck_q;
   assign sck_o  = sck_q;

   // Half-period counter and SCK flop; disabling parks SCK low and rearms the count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (!en_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (tick) begin
         cnt_q <= '0;
         sck_q <= ~sck_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/ptmch_spi_cmd_tx.sv
// ptmch_spi_cmd_tx: SPI mode-0 flash command initiator (opcode + up to
// P_MAX_BYTES-1 argument bytes). Optional MISO capture is built when the
// macro PTMCH_SPI_RX_EN is defined; the default build omits RX_DATA/RX_VALID.
`timescale 1ns/1ps
module ptmch_spi_cmd_tx
   import ptmch_pkg::*;
#(
   parameter int P_CLK_DIV   = 8,
   parameter int P_MAX_BYTES = 4,
   parameter int P_CS_GAP    = 16
) (
   input  logic                         CLK160M,
   input  logic                         RESET,
   input  logic                         CMD_VALID,
   output logic                         CMD_READY,
   input  logic [7:0]                   CMD_OPCODE,
   input  logic [8*(P_MAX_BYTES-1)-1:0] CMD_ARG,
   input  logic [2:0]                   CMD_NBYTES,
   output logic                         SPI_CS,
   output logic                         SPI_CLK,
   output logic                         SPI_MOSI,
   input  logic                         SPI_MISO,
   output logic                         BUSY,
   output logic                         DONE
`ifdef PTMCH_SPI_RX_EN
   ,
   output logic [8*(P_MAX_BYTES-1)-1:0] RX_DATA,
   output logic                         RX_VALID
`endif
);

   localparam int SW = 8 * P_MAX_BYTES;
   localparam int BW = $clog2(SW);
   localparam int TMAX = (2 * P_CLK_DIV > P_CS_GAP) ? 2 * P_CLK_DIV : P_CS_GAP;
   localparam int TW = $clog2(TMAX + 1);
   // HOLD covers the low half of the final bit plus the CS hold time.
   localparam logic [TW-1:0] HOLD_LAST = TW'(2 * P_CLK_DIV - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(P_CS_GAP - 1);

   spi_state_e    state_q, state_d;
   logic [SW-1:0] shreg_q, shreg_d;     // bits still to send after the one on MOSI
   logic [BW-1:0] bit_cnt_q, bit_cnt_d; // bits left minus one
   logic [TW-1:0] tmr_q, tmr_d;
   logic          cs_q, cs_d;
   logic          mosi_q, mosi_d;
   logic          done_q, done_d;
   logic [2:0]    nbytes_clamped;
   logic          sck_en, sck_rise, sck_fall;

   assign nbytes_clamped = 3'(clamp_nbytes(int'(CMD_NBYTES), P_MAX_BYTES));
   assign sck_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

   ptmch_spi_sck_gen #(
      .P_CLK_DIV(P_CLK_DIV)
   ) u_sck_gen (
      .clk_i (CLK160M),
      .rst_i (RESET),
      .en_i  (sck_en),
      .sck_o (SPI_CLK),
      .rise_o(sck_rise),
      .fall_o(sck_fall)
   );

`ifdef PTMCH_SPI_RX_EN
   logic [SW-9:0] rx_q, rx_d;
   logic [SW-9:0] rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic [2:0]    nbytes_q, nbytes_d;
   logic [SW-9:0] rx_aligned;

   // Opcode-phase bits fall off the top; argument bytes land MSB-aligned.
   assign rx_aligned = rx_q << (8 * (P_MAX_BYTES - int'(nbytes_q)));
   assign RX_DATA    = rx_data_q;
   assign RX_VALID   = rx_valid_q;
`else
   logic unused_miso;
   assign unused_miso = SPI_MISO;
`endif

   // Next-state and datapath decode; every target defaults to hold.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      tmr_d     = tmr_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
`ifdef PTMCH_SPI_RX_EN
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      nbytes_d   = nbytes_q;
      if (sck_rise) begin
         rx_d = {rx_q[SW-10:0], SPI_MISO};
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               shreg_d   = {CMD_OPCODE[6:0], CMD_ARG, 1'b0};
               mosi_d    = CMD_OPCODE[7];
               bit_cnt_d = BW'(8 * int'(nbytes_clamped) - 1);
               cs_d      = 1'b0;
               tmr_d     = '0;
               state_d   = ST_SETUP;
`ifdef PTMCH_SPI_RX_EN
               rx_d     = '0;
               nbytes_d = nbytes_clamped;
`endif
            end
         end
         ST_SETUP: begin
            if (sck_rise) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sck_fall) begin
               if (bit_cnt_q == '0) begin
                  tmr_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  mosi_d    = shreg_q[SW-1];
                  shreg_d   = {shreg_q[SW-2:0], 1'b0};
               end
            end
         end
         ST_HOLD: begin
            if (tmr_q == HOLD_LAST) begin
               tmr_d   = '0;
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_GAP;
`ifdef PTMCH_SPI_RX_EN
               rx_data_d  = rx_aligned;
               rx_valid_d = 1'b1;
`endif
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_q == GAP_LAST) begin
               tmr_d   = '0;
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset forces the idle bus levels at once.
   always_ff @(posedge CLK160M or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tmr_q     <= '0;
         cs_q      <= 1'b1;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef PTMCH_SPI_RX_EN
         rx_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         nbytes_q   <= 3'd1;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tmr_q     <= tmr_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
`ifdef PTMCH_SPI_RX_EN
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         nbytes_q   <= nbytes_d;
`endif
      end
   end

   assign SPI_CS    = cs_q;
   assign SPI_MOSI  = mosi_q;
   assign DONE      = done_q;
   assign CMD_READY = (state_q == ST_IDLE);
   assign BUSY      = (state_q != ST_IDLE);

endmodule
